// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus between the ALU control
// FSM (master) and the iterative divider (slave).
interface seq_restoring_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned iterative restoring divider: one quotient bit per cycle, MSB first.
// Each trial subtraction is done as R + ~D + 1 so the carry-out is the
// no-borrow flag, matching the CLA adder datapath it shares the ALU with.
module seq_restoring_divider #(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  seq_restoring_divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  // Working registers of the shift/subtract loop
  logic [WIDTH-1:0] part_r_q;
  logic [WIDTH-1:0] quo_w_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] part_r_d;
  logic [WIDTH-1:0] quo_w_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   sel;
  logic             no_borrow;
  logic             unused_sel_msb;

  wire accept = (state_q == IDLE) && bus.start;

  // One restoring iteration: shift {R,Q} left, trial-subtract D, keep or restore
  always_comb begin
    shifted            = {part_r_q, quo_w_q[WIDTH-1]};
    {no_borrow, diff}  = {1'b0, shifted} + {1'b0, ~{1'b0, dvsr_q}} + (WIDTH + 2)'(1);
    sel                = no_borrow ? diff : shifted;
    part_r_d           = sel[WIDTH-1:0];
    quo_w_d            = {quo_w_q[WIDTH-2:0], no_borrow};
  end

  // R < D always holds, so the selected value never needs its top bit
  assign unused_sel_msb = sel[WIDTH];

  // Datapath: load operands on accept, iterate while running
  always_ff @(posedge clk) begin
    if (accept) begin
      quo_w_q  <= bus.dividend;
      dvsr_q   <= bus.divisor;
      part_r_q <= '0;
    end else if (state_q == RUN) begin
      part_r_q <= part_r_d;
      quo_w_q  <= quo_w_d;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              // Division by zero resolves immediately without iterating
              quo_q   <= '1;
              rem_q   <= bus.dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            quo_q   <= quo_w_d;
            rem_q   <= part_r_d;
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks of the iterative divider against plain
// integer division, including latency, busy window and handshake behaviour.
module tb_seq_restoring_divider;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_quo"}, 32'(bus.quotient), 32'd0);
    check({tag, "_rem"}, 32'(bus.remainder), 32'd0);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
  endtask

  // Launch one division, optionally pulse start at two cycle offsets, and
  // compare everything against integer division.
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d,
                        input int pa, input int pb, input string tag);
    int lat;
    int busy_cnt;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    exp_q = (d == 0) ? {W{1'b1}} : W'(n / d);
    exp_r = (d == 0) ? n : W'(n % d);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = n; bus.divisor = d;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (1) begin
      if (bus.busy) busy_cnt++;
      if (bus.done || lat >= 40) break;
      @(negedge clk);
      lat++;
      if (lat == pa || lat == pb) begin
        bus.start = 1'b1; bus.dividend = 16'd7; bus.divisor = 16'd2;
      end else begin
        bus.start = 1'b0;
      end
    end
    check({tag, "_lat"}, 32'(lat), (d == 0) ? 32'd0 : 32'(W));
    check({tag, "_busywin"}, 32'(busy_cnt), 32'(lat + 1));
    check({tag, "_quo"}, 32'(bus.quotient), 32'(exp_q));
    check({tag, "_rem"}, 32'(bus.remainder), 32'(exp_r));
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(d == 0));
    if (d != 0) begin
      check({tag, "_inv"}, 32'(bus.quotient) * 32'(d) + 32'(bus.remainder), 32'(n));
      check({tag, "_rltd"}, 32'(bus.remainder < d), 32'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
    // Results stay held after the done pulse
    check({tag, "_quo_hold"}, 32'(bus.quotient), 32'(exp_q));
  endtask

  initial begin
    logic [W-1:0] rn;
    logic [W-1:0] rd;
    int mode;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    run_op(16'd100, 16'd7, -1, -1, "t1_100_7");
    run_op(16'hFFFF, 16'h0001, -1, -1, "t2_ffff_1");
    run_op(16'hFFFF, 16'hFFFF, -1, -1, "t2_ffff_ffff");
    run_op(16'd3, 16'd10, -1, -1, "t2_3_10");
    run_op(16'd5, 16'd0, -1, -1, "t3_5_0");
    run_op(16'd9, 16'd3, -1, -1, "t3_9_3");
    run_op(16'd1000, 16'd9, 5, 16, "t4_busy_start");

    // Asynchronous reset in the middle of a run clears outputs at once
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd50000; bus.divisor = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("t5_midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    run_op(16'd50000, 16'd3, -1, -1, "t5_after_rst");

    for (int i = 0; i < 2000; i++) begin
      mode = int'($urandom_range(0, 9));
      rn = W'($urandom);
      rd = W'($urandom);
      case (mode)
        0: rd = '0;
        1: rd = 16'd1;
        2: rn = '0;
        3: rd = W'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rn, rd, -1, -1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
